// File: rtl/seven_seg_scan_driver.sv
// Four-digit seven-segment scan controller: cycles en/num through a shadowed 16-bit value.
// Latency: outputs registered; a loaded value reaches the display at the next frame start (<= 4*REFRESH_DIV+1 clks).
// Backpressure: none; load is never refused, and a newer load overwrites an untransferred one. Optional: LEADING_ZERO_BLANK_EN.
module seven_seg_scan_driver #(
    parameter int REFRESH_DIV = 100000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] value_in,
    input  logic        load,
    output logic        load_ack,
    output logic [1:0]  en,
    output logic [3:0]  num,
    output logic        blank,
    output logic        frame_done
);

    localparam int CW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;

    logic [CW-1:0] cnt;
    logic [15:0]   shadow;
    logic [15:0]   pend_val;
    logic          pending;

    logic          tick;
    logic          boundary;
    logic [1:0]    en_nxt;
    logic [15:0]   shadow_nxt;
    logic [3:0]    num_nxt;
    logic          blank_nxt;

    always_comb begin
        tick       = (cnt == CW'(REFRESH_DIV - 1));
        boundary   = tick && (en == 2'd3);
        en_nxt     = tick ? en + 2'd1 : en;
        // num/blank are derived from the post-edge shadow so a frame swap never shows a stale nibble
        shadow_nxt = (boundary && pending) ? pend_val : shadow;
        num_nxt    = shadow_nxt[{en_nxt, 2'b00} +: 4];
        blank_nxt  = 1'b0;
`ifdef LEADING_ZERO_BLANK_EN
        case (en_nxt)
            2'd1:    blank_nxt = (shadow_nxt[15:4]  == 12'h000);
            2'd2:    blank_nxt = (shadow_nxt[15:8]  == 8'h00);
            2'd3:    blank_nxt = (shadow_nxt[15:12] == 4'h0);
            default: blank_nxt = 1'b0;
        endcase
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt        <= '0;
            en         <= 2'd0;
            num        <= 4'd0;
            blank      <= 1'b0;
            shadow     <= 16'h0000;
            pending    <= 1'b0;
            pend_val   <= 16'h0000;
            load_ack   <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            cnt        <= tick ? '0 : cnt + CW'(1);
            en         <= en_nxt;
            num        <= num_nxt;
            blank      <= blank_nxt;
            shadow     <= shadow_nxt;
            load_ack   <= boundary && pending;
            frame_done <= boundary;
            // a load on the boundary edge queues behind the value being transferred
            if (load) begin
                pend_val <= value_in;
                pending  <= 1'b1;
            end else if (boundary) begin
                pending  <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_seven_seg_scan_driver.sv
// Randomized bench for seven_seg_scan_driver against a frame-level model (REFRESH_DIV=4).
// Define LEADING_ZERO_BLANK_EN for both bench and RTL to exercise blanking.
module tb_seven_seg_scan_driver;

    localparam int DIV   = 4;
    localparam int FRAME = 4 * DIV;

    logic        clk;
    logic        rst_n;
    logic [15:0] value_in;
    logic        load;
    logic        load_ack;
    logic [1:0]  en;
    logic [3:0]  num;
    logic        blank;
    logic        frame_done;

    int checks;
    int errors;

    // model: time since reset release decides digit and frame edges; the rest is the load queue
    int          t;
    logic [15:0] m_shadow;
    logic [15:0] m_pend_val;
    bit          m_pending;
    bit          m_ack;
    bit          m_fd;

    seven_seg_scan_driver #(.REFRESH_DIV(DIV)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .value_in   (value_in),
        .load       (load),
        .load_ack   (load_ack),
        .en         (en),
        .num        (num),
        .blank      (blank),
        .frame_done (frame_done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0d, time %0t)", tag, got, exp, t, $time);
        end
    endtask

    function automatic logic [3:0] m_digit();
        return 4'((t / DIV) % 4);
    endfunction

    function automatic logic m_blank();
        logic [3:0] d;
        logic [15:0] upper;
        d = m_digit();
        upper = m_shadow >> (4 * d);
`ifdef LEADING_ZERO_BLANK_EN
        return (d != 0) && (upper == 16'h0000);
`else
        return 1'b0;
`endif
    endfunction

    task automatic check_outputs();
        logic [3:0] d;
        d = m_digit();
        chk("en",         {30'd0, en},        {28'd0, d});
        chk("num",        {28'd0, num},       {28'd0, 4'((m_shadow >> (4 * d)) & 16'h000F)});
        chk("blank",      {31'd0, blank},     {31'd0, m_blank()});
        chk("load_ack",   {31'd0, load_ack},  {31'd0, m_ack});
        chk("frame_done", {31'd0, frame_done},{31'd0, m_fd});
    endtask

    task automatic step(input bit ld, input logic [15:0] val);
        bit bnd;
        load     = ld;
        value_in = val;
        @(posedge clk);
        bnd   = ((t % FRAME) == FRAME - 1);
        m_ack = bnd && m_pending;
        m_fd  = bnd;
        if (bnd && m_pending) m_shadow = m_pend_val;
        if (ld) begin
            m_pend_val = val;
            m_pending  = 1'b1;
        end else if (bnd) begin
            m_pending = 1'b0;
        end
        t++;
        #1;
        check_outputs();
        load = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 16'h0000);
    endtask

    // advance until the next edge is at frame phase ph (ph = FRAME-1 means a boundary edge)
    task automatic run_to(input int ph);
        while ((t % FRAME) != ph) step(1'b0, 16'h0000);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        load  = 1'b1;
        value_in = 16'hBEEF;
        t = 0; m_shadow = 0; m_pend_val = 0; m_pending = 0; m_ack = 0; m_fd = 0;
        #1;
        check_outputs();
        repeat (3) @(posedge clk);
        #1;
        check_outputs();
        @(negedge clk);
        load  = 1'b0;
        rst_n = 1'b1;
    endtask

    initial begin
        checks = 0; errors = 0;
        rst_n = 1'b0; load = 1'b0; value_in = 16'h0000;
        t = 0; m_shadow = 0; m_pend_val = 0; m_pending = 0; m_ack = 0; m_fd = 0;
        #12;
        check_outputs();
        @(negedge clk);
        rst_n = 1'b1;

        idle(2 * FRAME + 3);

        run_to(6);
        step(1'b1, 16'h1A2F);
        idle(2 * FRAME);

        run_to(2);
        step(1'b1, 16'h1111);
        idle(3);
        step(1'b1, 16'h2222);
        idle(2 * FRAME);

        run_to(5);
        step(1'b1, 16'h3333);
        run_to(FRAME - 1);
        step(1'b1, 16'h4444);
        idle(2 * FRAME);

        step(1'b1, 16'h0050);
        idle(2 * FRAME);
        step(1'b1, 16'h0000);
        idle(2 * FRAME);

        run_to(3);
        step(1'b1, 16'h7777);
        idle(4);
        do_reset();
        idle(2 * FRAME);

        for (int i = 0; i < 1500; i++) begin
            logic [15:0] v;
            v = 16'($urandom);
            v = v >> (4 * $urandom_range(0, 3));
            if ($urandom_range(0, 299) == 0) begin
                do_reset();
            end else begin
                step($urandom_range(0, 11) == 0, v);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
